// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: ALU opcode encodings and the issue FSM state type.
package exe_pkg;

   localparam logic [2:0] OpNop = 3'b000;
   localparam logic [2:0] OpAdd = 3'b001;
   localparam logic [2:0] OpSub = 3'b010;
   localparam logic [2:0] OpAnd = 3'b011;
   localparam logic [2:0] OpOr  = 3'b100;
   localparam logic [2:0] OpXor = 3'b101;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StWb    = 2'd3
   } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the EXE-stage ALU interface: takes one decoded op, issues it to the
// clocked ALU, waits out the ALU latency and holds the result for writeback.
module alu_issue_ctrl
   import exe_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned OPC_W       = 3,
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned ALU_LATENCY = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  in_opcode,
   input  logic [DATA_W-1:0] in_src_a,
   input  logic [DATA_W-1:0] in_src_b,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [REG_AW-1:0] in_dest,
   output logic [DATA_W-1:0] alu_operand1,
   output logic [DATA_W-1:0] alu_operand2,
   output logic [OPC_W-1:0]  alu_opcode,
   output logic              alu_en,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_overflow,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_AW-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_overflow,
   output logic              ovf_sticky,
   input  logic              ovf_clear,
   output logic [CNT_W-1:0]  op_count
);

   localparam int unsigned WaitW = $clog2(ALU_LATENCY + 1);

   issue_state_e      r_state;
   issue_state_e      w_state_d;
   logic [OPC_W-1:0]  r_opcode;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic [REG_AW-1:0] r_dest;
   logic [WaitW-1:0]  r_wait_cnt;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_wb_ovf;
   logic              r_sticky;
   logic [CNT_W-1:0]  r_op_count;

   logic w_accept;
   logic w_issue;
   logic w_wait_done;
   logic w_wb_hs;

   assign in_ready    = (r_state == StIdle);
   assign alu_en      = (r_state == StIssue);
   assign wb_valid    = (r_state == StWb);
   assign w_accept    = in_valid && in_ready;
   assign w_issue     = alu_en;
   assign w_wait_done = (r_state == StWait) && (r_wait_cnt == WaitW'(1));
   assign w_wb_hs     = wb_valid && wb_ready;

   assign alu_operand1 = r_op1;
   assign alu_operand2 = r_op2;
   assign alu_opcode   = r_opcode;
   assign wb_dest      = r_dest;
   assign wb_data      = r_wb_data;
   assign wb_overflow  = r_wb_ovf;
   assign ovf_sticky   = r_sticky;
   assign op_count     = r_op_count;

   // Next-state logic: one op in flight, IDLE -> ISSUE -> WAIT -> WB -> IDLE.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (in_valid) w_state_d = StIssue;
         StIssue: w_state_d = StWait;
         StWait:  if (w_wait_done) w_state_d = StWb;
         StWb:    if (wb_ready) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // State register; reset abandons any op in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Operand latches, wait counter, result capture, sticky overflow and op counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode   <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_dest     <= '0;
         r_wait_cnt <= '0;
         r_wb_data  <= '0;
         r_wb_ovf   <= 1'b0;
         r_sticky   <= 1'b0;
         r_op_count <= '0;
      end else begin
         // Operand mux resolved at accept so the ALU sees stable values through WAIT.
         if (w_accept) begin
            r_opcode <= in_opcode;
            r_op1    <= in_src_a;
            r_op2    <= in_use_imm ? in_imm : in_src_b;
            r_dest   <= in_dest;
         end
         if (w_issue) begin
            r_wait_cnt <= WaitW'(ALU_LATENCY);
            if (r_op_count != '1) r_op_count <= r_op_count + 1'b1;
         end else if (r_state == StWait) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
         end
         if (w_wait_done) begin
            r_wb_data <= alu_result;
            r_wb_ovf  <= alu_overflow;
         end
         // A set on the handshake beats a simultaneous clear.
         if (w_wb_hs && r_wb_ovf) begin
            r_sticky <= 1'b1;
         end else if (ovf_clear) begin
            r_sticky <= 1'b0;
         end
      end
   end

endmodule
